irrigation_scheduler: RTL and testbench

Parametrised successor to the two-group watering controller. It drives NZONES irrigation zones, each with two valves (A/B), from 2-bit per-zone request codes. A global cap on simultaneously open valves is enforced with round-robin rotation between zones. Tank-level and line-pressure faults are debounced into a latched error state that closes all valves until an operator clear. It sits between the zone request logic and the valve drivers, alongside the water-level monitor.

---
 rtl/irrigation_scheduler_if.sv | 25 ++
 rtl/irrigation_scheduler.sv | 142 ++++++++++++++
 tb/tb_irrigation_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/irrigation_scheduler_if.sv
// Purpose : bundles the request, sensor and valve-drive signals of irrigation_scheduler.
// Latency : none (wires only).
// Backpressure: none; master drives the zone requests and sensors, slave drives valve/err/busy.
// Ports   : req (2 bits per zone), level, pres_fault, err_clr -> scheduler; valve, err, busy <- scheduler.
interface irrigation_scheduler_if #(
   parameter int NZONES = 4
) ();
   logic [2*NZONES-1:0] req;
   logic [1:0]          level;
   logic                pres_fault;
   logic                err_clr;
   logic [2*NZONES-1:0] valve;
   logic [1:0]          err;
   logic                busy;

   modport master (
      output req, level, pres_fault, err_clr,
      input  valve, err, busy
   );

   modport slave (
      input  req, level, pres_fault, err_clr,
      output valve, err, busy
   );
endinterface

// File: rtl/irrigation_scheduler.sv
// Purpose : grants per-zone A/B valve requests under a global open-valve cap with round-robin
//           rotation, and latches debounced dry-tank / pressure faults until an operator clear.
// Latency : 0 cycles; inputs sampled on an edge are reflected on the registered outputs of that edge.
// Backpressure: none; denied zones simply stay closed until the cap or rotation lets them in.
// Ports   : clk, reset (sync, active-high), bus (slave side: req/level/pres_fault/err_clr in,
//           valve/err/busy out).
module irrigation_scheduler #(
   parameter int NZONES      = 4,
   parameter int MAX_OPEN    = 3,
   parameter int DEBOUNCE    = 4,
   parameter int SLOT_CYCLES = 8
) (
   input logic                    clk,
   input logic                    reset,
   irrigation_scheduler_if.slave  bus
);
   localparam int RR_W   = $clog2(NZONES);
   localparam int DEB_W  = $clog2(DEBOUNCE + 1);
   localparam int SLOT_W = $clog2(SLOT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

   state_t              state_q, state_d;
   logic [2*NZONES-1:0] valve_q, valve_d;
   logic [1:0]          err_q, err_d;
   logic                busy_q;
   logic [RR_W-1:0]     rr_q, rr_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [DEB_W-1:0]    deb_q, deb_d;

   logic                dry, fc, any_req, deny;
   logic [2*NZONES-1:0] grant;
   logic [1:0]          zreq;
   int                  z, pc, run, lim;

   assign dry     = (bus.level == 2'b00);
   assign fc      = dry | bus.pres_fault;
   assign any_req = |bus.req;

   // Grant scan starting at rr. A zone is granted both its valves or nothing,
   // and a denied zone does not stop later zones that still fit.
   always_comb begin
      grant = '0;
      deny  = 1'b0;
      run   = 0;
      z     = 0;
      pc    = 0;
      zreq  = 2'b00;
      lim   = (bus.level == 2'b01) ? 1 : MAX_OPEN;
      for (int i = 0; i < NZONES; i++) begin
         z    = (int'(rr_q) + i) % NZONES;
         zreq = bus.req[2*z +: 2];
         pc   = int'(zreq[0]) + int'(zreq[1]);
         if (zreq != 2'b00) begin
            if (run + pc <= lim) begin
               grant[2*z +: 2] = zreq;
               run             = run + pc;
            end else begin
               deny = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      valve_d = valve_q;
      err_d   = err_q;
      rr_d    = rr_q;
      slot_d  = slot_q;
      deb_d   = deb_q;
      case (state_q)
         IDLE, RUN: begin
            deb_d = fc ? deb_q + DEB_W'(1) : '0;
            if (fc && deb_q == DEB_W'(DEBOUNCE - 1)) begin
               // Fault entry outranks every other transition.
               state_d = FAULT;
               valve_d = '0;
               err_d   = {bus.pres_fault, dry};
               deb_d   = '0;
               slot_d  = '0;
            end else if (state_q == IDLE) begin
               if (any_req && !dry) begin
                  state_d = RUN;
                  valve_d = grant;
               end
            end else if (!any_req) begin
               state_d = IDLE;
               valve_d = '0;
               slot_d  = '0;
            end else begin
               valve_d = grant;
               // Rotate only while someone is being starved.
               if (!deny) begin
                  slot_d = '0;
               end else if (slot_q == SLOT_W'(SLOT_CYCLES - 1)) begin
                  slot_d = '0;
                  rr_d   = (rr_q == RR_W'(NZONES - 1)) ? '0 : rr_q + RR_W'(1);
               end else begin
                  slot_d = slot_q + SLOT_W'(1);
               end
            end
         end
         FAULT: begin
            valve_d = '0;
            deb_d   = '0;
            if (bus.err_clr && !fc) begin
               state_d = IDLE;
               err_d   = 2'b00;
            end
         end
         default: begin
            state_d = IDLE;
            valve_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         valve_q <= '0;
         err_q   <= 2'b00;
         busy_q  <= 1'b0;
         rr_q    <= '0;
         slot_q  <= '0;
         deb_q   <= '0;
      end else begin
         state_q <= state_d;
         valve_q <= valve_d;
         err_q   <= err_d;
         busy_q  <= (state_d == RUN);
         rr_q    <= rr_d;
         slot_q  <= slot_d;
         deb_q   <= deb_d;
      end
   end

   assign bus.valve = valve_q;
   assign bus.err   = err_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_irrigation_scheduler.sv
module tb_irrigation_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   irrigation_scheduler_if #(.NZONES(4)) bus ();

   irrigation_scheduler #(
      .NZONES(4), .MAX_OPEN(3), .DEBOUNCE(4), .SLOT_CYCLES(8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [1:0] lvl;
      logic       pf;
      logic       clr;
      int         rep;
      logic [7:0] ev;
      logic [1:0] ee;
      logic       eb;
   } vec_t;

   typedef struct {
      logic [7:0] v;
      logic [1:0] e;
      logic       b;
      int         tag;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   task automatic add(input logic r, input logic [7:0] rq, input logic [1:0] lv, input logic pf,
                      input logic cl, input int rep, input logic [7:0] ev, input logic [1:0] ee,
                      input logic eb);
      vec_t t;
      t.rst = r; t.req = rq; t.lvl = lv; t.pf = pf; t.clr = cl; t.rep = rep;
      t.ev = ev; t.ee = ee; t.eb = eb;
      tbl.push_back(t);
   endtask

   task automatic check_out();
      exp_t x;
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL scoreboard_empty got=none want=entry");
      end else begin
         x = sb.pop_front();
         compared++;
         if (bus.valve !== x.v) begin
            mismatched++;
            $display("FAIL step%0d valve got=%h want=%h", x.tag, bus.valve, x.v);
         end
         compared++;
         if (bus.err !== x.e) begin
            mismatched++;
            $display("FAIL step%0d err got=%b want=%b", x.tag, bus.err, x.e);
         end
         compared++;
         if (bus.busy !== x.b) begin
            mismatched++;
            $display("FAIL step%0d busy got=%b want=%b", x.tag, bus.busy, x.b);
         end
      end
   endtask

   // Drive away from the active edge, queue what that edge must produce, check 1 ns after it.
   task automatic step(input logic r, input logic [7:0] rq, input logic [1:0] lv, input logic pf,
                       input logic cl, input logic [7:0] ev, input logic [1:0] ee, input logic eb,
                       input int tag);
      exp_t x;
      @(negedge clk);
      reset          = r;
      bus.req        = rq;
      bus.level      = lv;
      bus.pres_fault = pf;
      bus.err_clr    = cl;
      x.v = ev; x.e = ee; x.b = eb; x.tag = tag;
      sb.push_back(x);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req        = 8'h00;
      bus.level      = 2'b10;
      bus.pres_fault = 1'b0;
      bus.err_clr    = 1'b0;

      //   rst  req    lvl    pf    clr  rep  valve  err    busy
      add(1'b1, 8'h00, 2'b10, 1'b0, 1'b0, 1, 8'h00, 2'b00, 1'b0); // reset state
      add(1'b0, 8'h01, 2'b10, 1'b0, 1'b0, 1, 8'h01, 2'b00, 1'b1); // IDLE->RUN same edge
      add(1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 1, 8'h00, 2'b00, 1'b0); // drop -> IDLE
      add(1'b0, 8'h0F, 2'b10, 1'b0, 1'b0, 1, 8'h03, 2'b00, 1'b1); // rr=0: zone0 first
      add(1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 1, 8'h00, 2'b00, 1'b0);
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 1, 8'h13, 2'b00, 1'b1); // zone1 denied
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 8, 8'h13, 2'b00, 1'b1); // 8 denial edges, rr->1 on last
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 8, 8'h1C, 2'b00, 1'b1); // rr=1, 8 more edges -> rr=2
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 1, 8'h13, 2'b00, 1'b1); // rr=2: zone2, zone0
      add(1'b0, 8'h1F, 2'b01, 1'b0, 1'b0, 1, 8'h10, 2'b00, 1'b1); // low level: L=1
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 1, 8'h13, 2'b00, 1'b1);
      add(1'b0, 8'h1F, 2'b00, 1'b0, 1'b0, 3, 8'h13, 2'b00, 1'b1); // 3-edge dry pulse: no fault
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 1, 8'h13, 2'b00, 1'b1);
      add(1'b0, 8'h1F, 2'b00, 1'b0, 1'b0, 3, 8'h13, 2'b00, 1'b1);
      add(1'b0, 8'h1F, 2'b00, 1'b0, 1'b0, 1, 8'h00, 2'b01, 1'b0); // 4th dry edge -> FAULT
      add(1'b0, 8'h1F, 2'b00, 1'b0, 1'b1, 1, 8'h00, 2'b01, 1'b0); // clear while still dry
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b1, 1, 8'h00, 2'b00, 1'b0); // clear -> IDLE
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 1, 8'h13, 2'b00, 1'b1); // rr=3 -> RUN
      add(1'b0, 8'h1F, 2'b01, 1'b0, 1'b0, 1, 8'h10, 2'b00, 1'b1);
      add(1'b0, 8'h1F, 2'b00, 1'b1, 1'b0, 3, 8'h13, 2'b00, 1'b1);
      add(1'b0, 8'h1F, 2'b00, 1'b1, 1'b0, 1, 8'h00, 2'b11, 1'b0); // both faults
      add(1'b0, 8'h1F, 2'b10, 1'b1, 1'b1, 1, 8'h00, 2'b11, 1'b0); // pressure still bad
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b1, 1, 8'h00, 2'b00, 1'b0);
      add(1'b0, 8'hCF, 2'b10, 1'b0, 1'b0, 1, 8'hC0, 2'b00, 1'b1); // rr=3: zone3 first
      add(1'b1, 8'hCF, 2'b10, 1'b0, 1'b0, 1, 8'h00, 2'b00, 1'b0); // reset mid-RUN
      add(1'b0, 8'hCF, 2'b10, 1'b0, 1'b0, 1, 8'h03, 2'b00, 1'b1); // rr back to 0
      add(1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 1, 8'h00, 2'b00, 1'b0);
      add(1'b0, 8'h1F, 2'b00, 1'b0, 1'b0, 1, 8'h00, 2'b00, 1'b0); // dry blocks IDLE->RUN
      add(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 1, 8'h13, 2'b00, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].rep; k++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].lvl, tbl[i].pf, tbl[i].clr,
                 tbl[i].ev, tbl[i].ee, tbl[i].eb, i);
         end
      end

      // Pressure pulse of 3 edges, then a dry run into FAULT, then reset out of FAULT.
      for (int k = 0; k < 3; k++)
         step(1'b0, 8'h1F, 2'b10, 1'b1, 1'b0, 8'h13, 2'b00, 1'b1, 100);
      step(1'b0, 8'h1F, 2'b10, 1'b0, 1'b0, 8'h13, 2'b00, 1'b1, 101);
      for (int k = 0; k < 3; k++)
         step(1'b0, 8'h1F, 2'b00, 1'b0, 1'b0, 8'h13, 2'b00, 1'b1, 102);
      step(1'b0, 8'h1F, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 103);
      step(1'b1, 8'h1F, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 104);
      step(1'b0, 8'h0F, 2'b10, 1'b0, 1'b0, 8'h03, 2'b00, 1'b1, 105);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
